ctrl_pipe_chain: RTL and testbench



---
 rtl/ctrl_pipe_chain.sv | 84 ++++++++
 tb/tb_ctrl_pipe_chain.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// Multi-stage control-word pipeline with per-stage valid, stall and flush.
// Upstream stalls freeze earlier stages; a free stage behind a frozen one loads a bubble.
module ctrl_pipe_chain #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned STAGES = 3
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [WIDTH-1:0]          in_ctrl,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES*WIDTH-1:0]   stage_ctrl,
    output logic [STAGES-1:0]         stage_valid,
    output logic [3:0]                occupancy,
    output logic [15:0]               bubble_cnt
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] load_en;
    logic [STAGES-1:0] load_valid;
    logic [15:0]       bubble_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] src_ctrl;
        logic [WIDTH-1:0] ctrl_r;
        logic             src_valid;
        logic             src_bubble;
        logic             valid_r;

        // A stall anywhere at or beyond this stage freezes it.
        assign hold[g] = |(stall >> g);

        if (g == 0) begin : g_head
            assign src_ctrl   = in_valid ? in_ctrl : '0;
            assign src_valid  = in_valid;
            assign src_bubble = 1'b0;
        end else begin : g_body
            assign src_ctrl   = stage_ctrl[(g-1)*WIDTH +: WIDTH];
            assign src_valid  = stage_valid[g-1];
            assign src_bubble = hold[g-1];
        end

        assign load_en[g]    = ~flush[g] & ~hold[g];
        assign load_valid[g] = src_valid & ~src_bubble;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                ctrl_r  <= '0;
                valid_r <= 1'b0;
            end else if (flush[g]) begin
                ctrl_r  <= '0;
                valid_r <= 1'b0;
            end else if (!hold[g]) begin
                ctrl_r  <= src_bubble ? '0 : src_ctrl;
                valid_r <= load_valid[g];
            end
        end

        assign stage_ctrl[g*WIDTH +: WIDTH] = ctrl_r;
        assign stage_valid[g]               = valid_r;
    end

    assign in_ready = ~hold[0];

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            occupancy = occupancy + 4'(stage_valid[i]);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bubble_q <= '0;
        end else if (load_en[STAGES-1] && !load_valid[STAGES-1] && (bubble_q != '1)) begin
            bubble_q <= bubble_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed self-checking bench for ctrl_pipe_chain (3-stage main instance, 1-stage saturation instance).
module tb_ctrl_pipe_chain;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [11:0] in_ctrl;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic [35:0] stage_ctrl;
    logic [2:0]  stage_valid;
    logic [3:0]  occupancy;
    logic [15:0] bubble_cnt;

    logic [11:0] in_ctrl_1;
    logic        in_valid_1;
    logic        in_ready_1;
    logic [0:0]  stall_1;
    logic [0:0]  flush_1;
    logic [11:0] stage_ctrl_1;
    logic [0:0]  stage_valid_1;
    logic [3:0]  occupancy_1;
    logic [15:0] bubble_cnt_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    ctrl_pipe_chain #(.WIDTH(12), .STAGES(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .in_ctrl(in_ctrl), .in_valid(in_valid),
        .in_ready(in_ready), .stall(stall), .flush(flush), .stage_ctrl(stage_ctrl),
        .stage_valid(stage_valid), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    ctrl_pipe_chain #(.WIDTH(12), .STAGES(1)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .in_ctrl(in_ctrl_1), .in_valid(in_valid_1),
        .in_ready(in_ready_1), .stall(stall_1), .flush(flush_1), .stage_ctrl(stage_ctrl_1),
        .stage_valid(stage_valid_1), .occupancy(occupancy_1), .bubble_cnt(bubble_cnt_1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [11:0] sc(input int i);
        return stage_ctrl[i*12 +: 12];
    endfunction

    task automatic drive(input logic v, input logic [11:0] c);
        in_valid = v;
        in_ctrl  = c;
    endtask

    initial begin
        Rst_n = 1'b0; stall = '0; flush = '0; drive(1'b0, 12'h000);
        in_ctrl_1 = 12'hFFF; in_valid_1 = 1'b0; stall_1 = '0; flush_1 = '0;
        #1;
        check("rst_valid", 64'(stage_valid), 64'h0);
        check("rst_ctrl",  64'(stage_ctrl),  64'h0);
        check("rst_occ",   64'(occupancy),   64'h0);
        check("rst_cnt",   64'(bubble_cnt),  64'h0);
        check("rst_ready", 64'(in_ready),    64'h1);
        stall = 3'b100;
        #1 check("rst_ready_stall", 64'(in_ready), 64'h0);
        stall = '0;
        @(posedge Clk);
        #3 Rst_n = 1'b1;

        // Streaming: two leading bubbles leave stage 2 before 0x101 arrives
        drive(1'b1, 12'h101); tick();
        check("stream_s0", 64'(sc(0)), 64'h101);
        drive(1'b1, 12'h102); tick();
        drive(1'b1, 12'h103); tick();
        check("stream_s2_e3", 64'(sc(2)),      64'h101);
        check("stream_occ",   64'(occupancy),  64'd3);
        check("stream_cnt",   64'(bubble_cnt), 64'd2);
        drive(1'b1, 12'h201); tick();
        check("stream_s2_e4", 64'(sc(2)), 64'h102);
        drive(1'b1, 12'h202); tick();
        check("stream_s2_e5", 64'(sc(2)),      64'h103);
        check("stream_s1",    64'(sc(1)),      64'h201);
        check("stream_cnt2",  64'(bubble_cnt), 64'd2);

        // Stall stage 1 for two cycles
        stall = 3'b010; drive(1'b1, 12'h203);
        #1 check("stall_ready", 64'(in_ready), 64'h0);
        tick(); tick();
        check("stall_s0",    64'(sc(0)),       64'h202);
        check("stall_s1",    64'(sc(1)),       64'h201);
        check("stall_s2",    64'(sc(2)),       64'h000);
        check("stall_valid", 64'(stage_valid), 64'b011);
        check("stall_cnt",   64'(bubble_cnt),  64'd4);
        stall = '0;
        #1 check("release_ready", 64'(in_ready), 64'h1);
        tick();
        check("release_s2", 64'(sc(2)), 64'h201);
        check("release_s1", 64'(sc(1)), 64'h202);
        check("release_s0", 64'(sc(0)), 64'h203);

        // Invalid input is stored as zero
        drive(1'b0, 12'hFFF); tick();
        check("inv_s0",    64'(sc(0)),       64'h000);
        check("inv_valid", 64'(stage_valid), 64'b110);
        check("inv_s2",    64'(sc(2)),       64'h202);
        drive(1'b1, 12'h3FF); tick();
        drive(1'b1, 12'h301); tick();
        check("pre_flush_s1",  64'(sc(1)),      64'h3FF);
        check("pre_flush_cnt", 64'(bubble_cnt), 64'd5);

        // Flush over stall on stage 1
        stall = 3'b010; flush = 3'b010; drive(1'b1, 12'h302); tick();
        check("fos_s1",    64'(sc(1)),       64'h000);
        check("fos_s0",    64'(sc(0)),       64'h301);
        check("fos_valid", 64'(stage_valid), 64'b001);
        check("fos_occ",   64'(occupancy),   64'd1);
        check("fos_cnt",   64'(bubble_cnt),  64'd6);

        // Adjacent flushes: stage 1 must not pick up old stage 0
        stall = '0; flush = 3'b011; tick();
        check("dflush_valid", 64'(stage_valid), 64'b000);
        check("dflush_s1",    64'(sc(1)),       64'h000);
        check("dflush_cnt",   64'(bubble_cnt),  64'd7);
        flush = '0;

        // Refill, stall the last stage, then async reset mid-cycle
        drive(1'b1, 12'h401); tick();
        drive(1'b1, 12'h402); tick();
        drive(1'b1, 12'h403); tick();
        check("refill_valid", 64'(stage_valid), 64'b111);
        check("refill_cnt",   64'(bubble_cnt),  64'd9);
        stall = 3'b100; drive(1'b1, 12'h404);
        #1 check("s2stall_ready", 64'(in_ready), 64'h0);
        tick();
        check("s2stall_s2", 64'(sc(2)), 64'h401);
        check("s2stall_s0", 64'(sc(0)), 64'h403);
        #3 Rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(stage_valid), 64'h0);
        check("arst_ctrl",  64'(stage_ctrl),  64'h0);
        check("arst_cnt",   64'(bubble_cnt),  64'h0);
        check("arst_occ",   64'(occupancy),   64'h0);
        stall = '0; drive(1'b0, 12'h000);
        #1 Rst_n = 1'b1;
        drive(1'b1, 12'h501); tick();
        drive(1'b0, 12'h000); tick(); tick();
        check("resume_s2",    64'(sc(2)),       64'h501);
        check("resume_valid", 64'(stage_valid), 64'b100);
        check("resume_cnt",   64'(bubble_cnt),  64'd2);

        // Single-stage instance: hold is just stall[0], counter saturates
        stall_1 = 1'b1;
        #1 check("s1_ready", 64'(in_ready_1), 64'h0);
        stall_1 = 1'b0;
        force u1.bubble_q = 16'hFFFE;
        #1 release u1.bubble_q;
        check("sat_preload", 64'(bubble_cnt_1), 64'hFFFE);
        tick();
        check("sat_1", 64'(bubble_cnt_1), 64'hFFFF);
        tick();
        check("sat_2", 64'(bubble_cnt_1), 64'hFFFF);
        tick();
        check("sat_3",     64'(bubble_cnt_1),  64'hFFFF);
        check("s1_valid",  64'(stage_valid_1), 64'h0);
        check("s1_ctrl",   64'(stage_ctrl_1),  64'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
